// File: rtl/muldiv_ctrl.sv
`timescale 1ns/1ps
// muldiv_ctrl: sequencer for the iterative multiply/divide datapath.
// A MULTU or DIVU request clears both units for one cycle (LOAD), clocks them
// with the operation code for ITER cycles (RUN), issues the output code
// (OUT), then captures the 2W-bit result into HI/LO and pulses done (DONE).
// MFHI/MFLO reads return HI or LO on rd_data one cycle after the request.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, funct        request strobe and function code
//   mul_out, div_out    result buses from the multiplier and divider units
//   unit_reset          load/clear pulse to both units
//   unit_signal         Signal bus to both units (0 = hold)
//   unit_sel            0 = multiplier, 1 = divider, held for the operation
//   busy, stall         operation in flight / request refused this cycle
//   done, illegal       HI/LO just updated / unsupported request
//   hi, lo              HI and LO registers
//   rd_data, rd_valid   MFHI/MFLO result and its one-cycle strobe
module muldiv_ctrl #(
  parameter int unsigned ITER = 32,
  parameter int unsigned W    = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [5:0]     funct,
  input  logic [2*W-1:0] mul_out,
  input  logic [2*W-1:0] div_out,
  output logic           unit_reset,
  output logic [5:0]     unit_signal,
  output logic           unit_sel,
  output logic           busy,
  output logic           stall,
  output logic           done,
  output logic           illegal,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic [W-1:0]   rd_data,
  output logic           rd_valid
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] SIG_OUT = 6'd63;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [CW-1:0] count;
  logic [5:0]    op;
  logic          can_accept;
  logic          is_op;
  logic          is_rd;
  logic          accept_op;
  logic          accept_rd;

  // DONE accepts new work exactly like IDLE, which allows back-to-back ops.
  assign can_accept = (state == S_IDLE) || (state == S_DONE);
  assign is_op      = (funct == F_MULTU) || (funct == F_DIVU);
  assign is_rd      = (funct == F_MFHI) || (funct == F_MFLO);
  assign accept_op  = start && can_accept && is_op;
  assign accept_rd  = start && can_accept && is_rd;

  assign busy       = (state == S_LOAD) || (state == S_RUN) || (state == S_OUT);
  assign stall      = start && busy;
  assign done       = (state == S_DONE);
  assign illegal    = start && can_accept && !is_op && !is_rd && !reset;
  assign unit_reset = reset || (state == S_LOAD);

  always_comb begin
    unit_signal = 6'd0;
    if (state == S_RUN) begin
      unit_signal = op;
    end else if (state == S_OUT) begin
      unit_signal = SIG_OUT;
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = accept_op ? S_LOAD : S_IDLE;
      S_LOAD:  state_next = S_RUN;
      S_RUN:   state_next = (count == LAST) ? S_OUT : S_RUN;
      S_OUT:   state_next = S_DONE;
      S_DONE:  state_next = accept_op ? S_LOAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      op       <= 6'd0;
      unit_sel <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_next;
      rd_valid <= accept_rd;
      if (accept_rd) begin
        rd_data <= (funct == F_MFHI) ? hi : lo;
      end
      if (accept_op) begin
        op       <= funct;
        unit_sel <= (funct == F_DIVU);
      end
      // Cleared while in LOAD so RUN always starts from zero; saturates at LAST.
      if (state == S_LOAD) begin
        count <= '0;
      end else if ((state == S_RUN) && (count != LAST)) begin
        count <= count + CW'(1);
      end
      if (state == S_OUT) begin
        {hi, lo} <= unit_sel ? div_out : mul_out;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int unsigned ITER = 32;
  localparam int unsigned W    = 32;
  localparam int K_DONE = 0;
  localparam int K_RD   = 1;
  localparam int K_ILL  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    funct = 6'd0;
  logic [63:0]   mul_out = 64'd0;
  logic [63:0]   div_out = 64'd0;
  logic          unit_reset;
  logic [5:0]    unit_signal;
  logic          unit_sel;
  logic          busy;
  logic          stall;
  logic          done;
  logic          illegal;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   rd_data;
  logic          rd_valid;

  muldiv_ctrl #(.ITER(ITER), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct      (funct),
    .mul_out    (mul_out),
    .div_out    (div_out),
    .unit_reset (unit_reset),
    .unit_signal(unit_signal),
    .unit_sel   (unit_sel),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .illegal    (illegal),
    .hi         (hi),
    .lo         (lo),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void pop_cmp(input int kind, input logic [63:0] val);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got output kind %0d value %0h, expected nothing", kind, val);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", kind, e.kind);
      chk("sb_val", val, e.val);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (done)     pop_cmp(K_DONE, {hi, lo});
        if (rd_valid) pop_cmp(K_RD, {32'd0, rd_data});
        if (illegal)  pop_cmp(K_ILL, 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // One multiply/divide op observed cycle by cycle; n counts cycles after the
  // edge that samples start (n=1 is LOAD, n=35 is DONE).
  task automatic run_op(input logic [5:0] op, input logic [63:0] exp_val, input bit pre,
                        input int stall_at, input int abort_at, input bit chain);
    int   n_rst = 0;
    int   n_sig = 0;
    int   n_out = 0;
    int   n_sel = 0;
    int   n_busy = 0;
    int   n_done = 0;
    int   done_at = 0;
    int   last;
    logic sel_e;
    last  = chain ? 35 : 40;
    sel_e = (op == 6'd27);
    if (!pre) begin
      if (abort_at == 0) sb.push_back('{K_DONE, exp_val});
      @(negedge clk);
      start = 1'b1;
      funct = op;
    end
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (n == abort_at);
      if (n == stall_at) begin
        start = 1'b1;
        funct = 6'd25;
      end
      if (chain && n == last) begin
        sb.push_back('{K_DONE, exp_val});
        start = 1'b1;
        funct = 6'd25;
      end
      #1;
      if (unit_reset) n_rst++;
      if (unit_signal == op) n_sig++;
      if (unit_signal == 6'd63) n_out++;
      if (busy) n_busy++;
      if (n <= 35 && unit_sel !== sel_e) n_sel++;
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = n;
      end
      if (n == stall_at) chk("stall_while_busy", {busy, stall}, 2'b11);
      if (abort_at != 0 && n == abort_at + 1) chk("abort_idle_cleared", {busy, hi, lo}, 0);
      if (pre && n == 1) chk("b2b_load_no_gap", {unit_reset, busy}, 2'b11);
    end
    reset = 1'b0;
    if (abort_at != 0) begin
      chk("abort_no_done", n_done, 0);
    end else begin
      chk("done_latency", done_at, 35);
      chk("done_count", n_done, 1);
      chk("load_cycles", n_rst, 1);
      chk("run_cycles", n_sig, ITER);
      chk("out_cycles", n_out, 1);
      chk("busy_cycles", n_busy, 34);
      chk("unit_sel_held", n_sel, 0);
    end
  endtask

  task automatic do_read(input logic [5:0] f, input logic [31:0] exp_d);
    sb.push_back('{K_RD, {32'd0, exp_d}});
    @(negedge clk);
    start = 1'b1;
    funct = f;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("rd_valid_data", {rd_valid, rd_data}, {1'b1, exp_d});
    chk("rd_not_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("rd_valid_single", rd_valid, 0);
  endtask

  initial begin
    // Reset phase: unit_reset follows reset.
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset_unit_reset", unit_reset, 1);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("idle_ctrl", {busy, stall, done, illegal, rd_valid, unit_reset, unit_sel, unit_signal}, 0);
      chk("idle_hilo", {hi, lo}, 0);
      chk("idle_rd_data", rd_data, 0);
    end

    mul_out = 64'h00000001_00000002;
    div_out = 64'h00000003_00000007;
    run_op(6'd25, 64'h00000001_00000002, 1'b0, 0, 0, 1'b0);
    chk("multu_hilo", {hi, lo}, 64'h00000001_00000002);
    run_op(6'd27, 64'h00000003_00000007, 1'b0, 0, 0, 1'b0);
    chk("divu_hilo", {hi, lo}, 64'h00000003_00000007);
    do_read(6'd16, 32'd3);
    do_read(6'd18, 32'd7);

    // Request during RUN cycle 10 is refused; the op completes once.
    run_op(6'd25, 64'h00000001_00000002, 1'b0, 11, 0, 1'b0);

    // Reset during RUN cycle 20 aborts, then a fresh op completes.
    run_op(6'd25, 64'd0, 1'b0, 0, 21, 1'b0);
    mul_out = 64'h0000000A_0000000B;
    run_op(6'd25, 64'h0000000A_0000000B, 1'b0, 0, 0, 1'b0);
    chk("fresh_hilo", {hi, lo}, 64'h0000000A_0000000B);

    // Unsupported funct in IDLE.
    sb.push_back('{K_ILL, 64'd0});
    @(negedge clk);
    start = 1'b1;
    funct = 6'd0;
    #1;
    chk("illegal_pulse", {illegal, busy}, 2'b10);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("illegal_once", {illegal, busy}, 2'b00);

    // Back-to-back: second MULTU accepted in the DONE cycle.
    mul_out = 64'h12345678_9ABCDEF0;
    run_op(6'd25, 64'h12345678_9ABCDEF0, 1'b0, 0, 0, 1'b1);
    run_op(6'd25, 64'h12345678_9ABCDEF0, 1'b1, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    #3;
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the iterative multiply/divide datapath: accepts a function code from ALU control and drives the multiplier/divider unit's reset and 6-bit Signal inputs for a fixed iteration count, then issues OUT.
- Captures the 64-bit result into internal HI/LO registers and services MFHI/MFLO reads.
- Raises stall to the pipeline while an operation is in flight.

Parameters:
- ITER, 32, number of RUN cycles the unit is clocked with the operation Signal.
- W, 32, operand/HI/LO width; unit result width is 2*W.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe, qualified by funct
- funct  input  6  MULTU=25 (6'b011001), DIVU=27 (6'b011011), MFHI=16, MFLO=18
- mul_out  input  2W  multiplier unit dataOut
- div_out  input  2W  divider unit dataOut
- unit_reset  output  1  load/clear pulse to both units
- unit_signal  output  6  Signal bus to both units
- unit_sel  output  1  0=multiplier, 1=divider; held for whole operation
- busy  output  1  operation in flight
- stall  output  1  start & busy (request refused this cycle)
- done  output  1  one-cycle pulse: HI/LO just updated
- illegal  output  1  one-cycle pulse: start with unsupported funct while not busy
- hi  output  W  HI register
- lo  output  W  LO register
- rd_data  output  W  MFHI/MFLO result, registered
- rd_valid  output  1  one-cycle pulse with rd_data

Behaviour:
- Reset values: state=IDLE, counter=0, hi=lo=0, rd_data=0, unit_signal=0, unit_sel=0, busy=stall=done=illegal=rd_valid=0.
- unit_reset = reset | (state==LOAD).
- Reset mid-operation aborts the op, returns to IDLE and leaves HI/LO=0.
- States:
  - IDLE: unit_signal=0.
  - LOAD: one cycle; unit_reset=1.
  - RUN: ITER cycles; unit_signal=op code, counter counts 0..ITER-1.
  - OUT: one cycle; unit_signal=63.
  - DONE: one cycle; done=1.
- Transitions:
  - IDLE/DONE + start + (MULTU|DIVU) -> LOAD; latch op and unit_sel (DIVU -> 1).
  - LOAD -> RUN.
  - RUN with counter==ITER-1 -> OUT; otherwise stay in RUN.
  - OUT -> DONE.
  - DONE -> IDLE unless a new start is accepted.
- HI/LO capture: on the clock edge ending OUT, {hi,lo} <= (unit_sel ? div_out : mul_out).
- Latency: start sampled at edge E0; LOAD runs E0..E1, RUN E1..E(ITER+1), OUT up to E(ITER+2), done high in the cycle after E(ITER+2). Total ITER+3 cycles, i.e. 35 for the default.
- busy=1 in LOAD, RUN and OUT; busy=0 in IDLE and DONE.
- Start while busy: ignored, no queueing, stall=1 that cycle.
- MFHI/MFLO: accepted in IDLE or DONE. rd_data <= hi (MFHI) or lo (MFLO) at the next edge, rd_valid=1 for one cycle, state unchanged.
  - In DONE the read returns the freshly captured values.
  - While busy, the request is stalled.
- Unsupported funct with start while not busy: illegal pulses for one cycle, no state change.
- unit_signal is 0 outside RUN and OUT, so the units hold their values.
- Counter width: clog2(ITER) bits. It is cleared on entry to RUN and never wraps inside RUN.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, unit_signal=0, unit_reset high only during reset.
- start, funct=25; bench model holds mul_out=64'h00000001_00000002 -> unit_reset for 1 cycle, unit_signal=25 for exactly 32 cycles, 63 for 1 cycle, done 35 cycles after start, hi=1, lo=2, unit_sel=0.
- start, funct=27 with div_out=64'h00000003_00000007 -> unit_sel=1 throughout, hi=3, lo=7. Then MFHI -> rd_data=3 with rd_valid one cycle later; MFLO -> rd_data=7.
- start funct=25 at cycle 10 of RUN -> stall=1 that cycle, counter/op unchanged, single done.
- Assert reset at RUN cycle 20 -> IDLE next edge, hi=lo=0, no done pulse; a fresh MULTU afterward completes normally.
- start funct=0 in IDLE -> illegal pulses once, busy stays 0. Back-to-back MULTU accepted in the DONE cycle -> LOAD immediately, no IDLE gap.
